boom_mshr_file_param: RTL and testbench

- Parametrised miss-status file: NMSHR independent miss entries, each with its own replay queue (RPQ) of depth NRPQ.
- Accepts cache-miss requests, allocates primary misses, and merges secondary misses to the same block.
- Issues one Acquire per entry, counts refill grant beats, replays queued requests in order, then sends GrantAck (Finish).
- Sits between the L1 D-cache miss path and the TileLink A/D/E channel adapters.

---
 rtl/mshr_file_pkg.sv | 32 +++
 rtl/mshr_rpq_fifo.sv | 73 +++++++
 rtl/boom_mshr_file_param.sv | 219 +++++++++++++++++++++
 tb/tb_boom_mshr_file_param.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mshr_file_pkg.sv
// Shared types for the MSHR file.
//   mshr_state_e : per-entry lifecycle (INVALID -> ACQ -> WAIT_GNT -> DRAIN -> FINISH)
//   mshr_entry_t : per-entry record (state, block address, refill beat counter)
//   blk_addr()   : strips the block offset from a physical address
// Block address and beat counter fields are sized for the widest supported
// configuration. The top zero-extends into them, so full-width compares are exact.
package mshr_file_pkg;

  localparam int MAX_BLK_W  = 64;
  localparam int MAX_BEAT_W = 8;

  typedef enum logic [2:0] {
    INVALID,
    ACQ,
    WAIT_GNT,
    DRAIN,
    FINISH
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e           state;
    logic [MAX_BLK_W-1:0]  blk;
    logic [MAX_BEAT_W-1:0] beats;
  } mshr_entry_t;

  // Block address of a zero-extended physical address.
  function automatic logic [MAX_BLK_W-1:0] blk_addr(input logic [63:0] addr,
                                                     input int unsigned blk_off);
    return addr >> blk_off;
  endfunction

endpackage

// File: rtl/mshr_rpq_fifo.sv
// Replay queue for one MSHR entry: synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset (clears pointers/count)
//   push_i, data_i   : enqueue a request id
//   pop_i            : dequeue the head (ignored when empty)
//   data_o           : current head, valid whenever empty_o is low
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored ids (log2(DEPTH)+1 bits)
module mshr_rpq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/boom_mshr_file_param.sv
// Miss-status holding register file.
// Each of NMSHR entries tracks one outstanding cache-line miss: it issues one
// Acquire, counts BEATS Grant beats, replays its queued request ids in arrival
// order, then sends a GrantAck. Secondary misses to an in-flight block are
// merged into that entry's replay queue.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   i_req_* / o_req_ready/o_req_sec : miss request in, accept and merged flag out
//   o_acq_* / i_acq_ready         : Acquire (block-aligned address, entry index)
//   i_gnt_valid, i_gnt_source     : Grant beats (always accepted)
//   o_replay_* / i_replay_ready   : replayed request ids, entry being drained
//   o_fin_* / i_fin_ready         : GrantAck
//   o_gnt_err                     : one-cycle pulse for a Grant to an entry not waiting
//   o_idle                        : every entry INVALID
module boom_mshr_file_param
  import mshr_file_pkg::*;
#(
  parameter int NMSHR   = 4,
  parameter int NRPQ    = 8,
  parameter int PADDR_W = 32,
  parameter int BLK_OFF = 6,
  parameter int BEATS   = 4,
  parameter int ID_W    = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [PADDR_W-1:0]       i_req_addr,
  input  logic [ID_W-1:0]          i_req_id,
  output logic                     o_req_sec,
  output logic                     o_acq_valid,
  input  logic                     i_acq_ready,
  output logic [PADDR_W-1:0]       o_acq_addr,
  output logic [$clog2(NMSHR)-1:0] o_acq_source,
  input  logic                     i_gnt_valid,
  input  logic [$clog2(NMSHR)-1:0] i_gnt_source,
  output logic                     o_replay_valid,
  input  logic                     i_replay_ready,
  output logic [ID_W-1:0]          o_replay_id,
  output logic [$clog2(NMSHR)-1:0] o_replay_entry,
  output logic                     o_fin_valid,
  input  logic                     i_fin_ready,
  output logic [$clog2(NMSHR)-1:0] o_fin_source,
  output logic                     o_gnt_err,
  output logic                     o_idle
);

  localparam int SW = $clog2(NMSHR);
  localparam int CW = $clog2(NRPQ) + 1;
  localparam logic [MAX_BEAT_W-1:0] LAST_BEAT = MAX_BEAT_W'(BEATS - 1);

  mshr_entry_t ent_q [NMSHR];
  mshr_entry_t ent_d [NMSHR];

  logic [NMSHR-1:0] match_vec, free_vec, acq_cand, rep_cand, fin_cand;
  logic [NMSHR-1:0] rpq_full, rpq_empty, rpq_push, rpq_pop;
  logic [ID_W-1:0]  rpq_head  [NMSHR];
  logic [CW-1:0]    rpq_count [NMSHR];

  logic [MAX_BLK_W-1:0] req_blk;
  logic [SW-1:0] match_idx, free_idx, acq_first, rep_first, fin_first;
  logic [SW-1:0] acq_idx, rep_idx, fin_idx;
  logic          any_match, merge_ok, req_fire, merge_fire, alloc_fire;
  logic          acq_fire, rep_fire, fin_fire, gnt_hit;

  // Arbiter locks: once an entry is presented and stalled, it stays presented
  // even if a lower-index entry becomes eligible in the meantime.
  logic          acq_lock_q, acq_lock_d, rep_lock_q, rep_lock_d, fin_lock_q, fin_lock_d;
  logic [SW-1:0] acq_lock_idx_q, rep_lock_idx_q, fin_lock_idx_q;
  logic          gnt_err_q, gnt_err_d;

  assign req_blk = blk_addr(64'(i_req_addr), BLK_OFF);

  for (genvar gi = 0; gi < NMSHR; gi++) begin : g_entry
    assign match_vec[gi] = (ent_q[gi].state != INVALID) && (ent_q[gi].blk == req_blk);
    assign free_vec[gi]  = (ent_q[gi].state == INVALID);
    assign acq_cand[gi]  = (ent_q[gi].state == ACQ);
    assign rep_cand[gi]  = (ent_q[gi].state == DRAIN) && !rpq_empty[gi];
    assign fin_cand[gi]  = (ent_q[gi].state == FINISH);

    assign rpq_push[gi] = (merge_fire && match_idx == SW'(gi)) ||
                          (alloc_fire && free_idx == SW'(gi));
    assign rpq_pop[gi]  = rep_fire && rep_idx == SW'(gi);

    mshr_rpq_fifo #(
      .DEPTH(NRPQ),
      .WIDTH(ID_W)
    ) u_rpq (
      .clk_i  (clock),
      .rst_i  (reset),
      .push_i (rpq_push[gi]),
      .data_i (i_req_id),
      .pop_i  (rpq_pop[gi]),
      .data_o (rpq_head[gi]),
      .full_o (rpq_full[gi]),
      .empty_o(rpq_empty[gi]),
      .count_o(rpq_count[gi])
    );
  end

  // Lowest-index-first encoders (descending scan so the lowest hit wins).
  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    acq_first = '0;
    rep_first = '0;
    fin_first = '0;
    for (int i = NMSHR - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = SW'(i);
      if (free_vec[i])  free_idx  = SW'(i);
      if (acq_cand[i])  acq_first = SW'(i);
      if (rep_cand[i])  rep_first = SW'(i);
      if (fin_cand[i])  fin_first = SW'(i);
    end
  end

  // Request acceptance: merge into the matching entry, else allocate.
  assign any_match   = |match_vec;
  assign merge_ok    = any_match && !rpq_full[match_idx] &&
                       (ent_q[match_idx].state == ACQ || ent_q[match_idx].state == WAIT_GNT);
  assign o_req_ready = any_match ? merge_ok : (|free_vec);
  assign o_req_sec   = i_req_valid && merge_ok;
  assign req_fire    = i_req_valid && o_req_ready;
  assign merge_fire  = req_fire && any_match;
  assign alloc_fire  = req_fire && !any_match;

  // Channel arbitration.
  assign acq_idx     = acq_lock_q ? acq_lock_idx_q : acq_first;
  assign rep_idx     = rep_lock_q ? rep_lock_idx_q : rep_first;
  assign fin_idx     = fin_lock_q ? fin_lock_idx_q : fin_first;
  assign o_acq_valid    = acq_lock_q | (|acq_cand);
  assign o_replay_valid = rep_lock_q | (|rep_cand);
  assign o_fin_valid    = fin_lock_q | (|fin_cand);
  assign acq_fire    = o_acq_valid && i_acq_ready;
  assign rep_fire    = o_replay_valid && i_replay_ready;
  assign fin_fire    = o_fin_valid && i_fin_ready;
  assign acq_lock_d  = o_acq_valid && !i_acq_ready;
  assign rep_lock_d  = o_replay_valid && !i_replay_ready;
  assign fin_lock_d  = o_fin_valid && !i_fin_ready;

  // Payloads are forced to zero while their valid is low.
  assign o_acq_addr     = o_acq_valid ? PADDR_W'(ent_q[acq_idx].blk << BLK_OFF) : '0;
  assign o_acq_source   = o_acq_valid ? acq_idx : '0;
  assign o_replay_id    = o_replay_valid ? rpq_head[rep_idx] : '0;
  assign o_replay_entry = o_replay_valid ? rep_idx : '0;
  assign o_fin_source   = o_fin_valid ? fin_idx : '0;

  assign gnt_hit   = i_gnt_valid && (ent_q[i_gnt_source].state == WAIT_GNT);
  assign gnt_err_d = i_gnt_valid && !gnt_hit;
  assign o_gnt_err = gnt_err_q;
  assign o_idle    = &free_vec;

  // Per-entry next state.
  always_comb begin
    for (int i = 0; i < NMSHR; i++) begin
      ent_d[i] = ent_q[i];
      case (ent_q[i].state)
        INVALID: begin
          if (alloc_fire && free_idx == SW'(i)) begin
            ent_d[i].state = ACQ;
            ent_d[i].blk   = req_blk;
            ent_d[i].beats = '0;
          end
        end
        ACQ: begin
          if (acq_fire && acq_idx == SW'(i)) ent_d[i].state = WAIT_GNT;
        end
        WAIT_GNT: begin
          if (gnt_hit && i_gnt_source == SW'(i)) begin
            if (ent_q[i].beats == LAST_BEAT) begin
              ent_d[i].beats = '0;
              ent_d[i].state = DRAIN;
            end else begin
              ent_d[i].beats = ent_q[i].beats + MAX_BEAT_W'(1);
            end
          end
        end
        DRAIN: begin
          // Leave as the last queued id is popped.
          if (rpq_pop[i] && rpq_count[i] == CW'(1)) ent_d[i].state = FINISH;
        end
        FINISH: begin
          if (fin_fire && fin_idx == SW'(i)) ent_d[i].state = INVALID;
        end
        default: ent_d[i].state = INVALID;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NMSHR; i++) begin
        ent_q[i].state <= INVALID;
        ent_q[i].blk   <= '0;
        ent_q[i].beats <= '0;
      end
      acq_lock_q     <= 1'b0;
      rep_lock_q     <= 1'b0;
      fin_lock_q     <= 1'b0;
      acq_lock_idx_q <= '0;
      rep_lock_idx_q <= '0;
      fin_lock_idx_q <= '0;
      gnt_err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NMSHR; i++) begin
        ent_q[i] <= ent_d[i];
      end
      acq_lock_q     <= acq_lock_d;
      rep_lock_q     <= rep_lock_d;
      fin_lock_q     <= fin_lock_d;
      acq_lock_idx_q <= acq_idx;
      rep_lock_idx_q <= rep_idx;
      fin_lock_idx_q <= fin_idx;
      gnt_err_q      <= gnt_err_d;
    end
  end

endmodule

// File: tb/tb_boom_mshr_file_param.sv
module tb_boom_mshr_file_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [5:0]  i_req_id;
  logic        o_req_sec;
  logic        o_acq_valid;
  logic        i_acq_ready;
  logic [31:0] o_acq_addr;
  logic [1:0]  o_acq_source;
  logic        i_gnt_valid;
  logic [1:0]  i_gnt_source;
  logic        o_replay_valid;
  logic        i_replay_ready;
  logic [5:0]  o_replay_id;
  logic [1:0]  o_replay_entry;
  logic        o_fin_valid;
  logic        i_fin_ready;
  logic [1:0]  o_fin_source;
  logic        o_gnt_err;
  logic        o_idle;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  boom_mshr_file_param dut (
    .clock         (clock),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_id      (i_req_id),
    .o_req_sec     (o_req_sec),
    .o_acq_valid   (o_acq_valid),
    .i_acq_ready   (i_acq_ready),
    .o_acq_addr    (o_acq_addr),
    .o_acq_source  (o_acq_source),
    .i_gnt_valid   (i_gnt_valid),
    .i_gnt_source  (i_gnt_source),
    .o_replay_valid(o_replay_valid),
    .i_replay_ready(i_replay_ready),
    .o_replay_id   (o_replay_id),
    .o_replay_entry(o_replay_entry),
    .o_fin_valid   (o_fin_valid),
    .i_fin_ready   (i_fin_ready),
    .o_fin_source  (o_fin_source),
    .o_gnt_err     (o_gnt_err),
    .o_idle        (o_idle)
  );

  // Drives one entry (alone in ACQ) through Acquire, BEATS grants, a single
  // replay and Finish. Entered and left just after a falling edge.
  task automatic run_entry(input int src, input logic [31:0] addr, input logic [5:0] id);
    i_acq_ready = 1'b1;
    #1;
    checks++;
    if (o_acq_valid !== 1'b1 || o_acq_addr !== addr || o_acq_source !== 2'(src)) begin
      errors++;
      $display("FAIL run_acq: got v=%0b addr=%h src=%0d, expected v=1 addr=%h src=%0d",
               o_acq_valid, o_acq_addr, o_acq_source, addr, src);
    end
    $display("acq   src=%0d addr=%h", o_acq_source, o_acq_addr);
    @(negedge clock);
    i_acq_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_gnt_valid  = 1'b1;
      i_gnt_source = 2'(src);
      #1;
      if (b == 3) begin
        checks++;
        if (o_replay_valid !== 1'b0) begin
          errors++;
          $display("FAIL run_early_replay: got replay_valid=%0b after 3 beats, expected 0", o_replay_valid);
        end
      end
      @(negedge clock);
    end
    i_gnt_valid = 1'b0;
    #1;
    checks++;
    if (o_replay_valid !== 1'b1 || o_replay_id !== id || o_replay_entry !== 2'(src)) begin
      errors++;
      $display("FAIL run_replay: got v=%0b id=%0d entry=%0d, expected v=1 id=%0d entry=%0d",
               o_replay_valid, o_replay_id, o_replay_entry, id, src);
    end
    $display("replay entry=%0d id=%0d", o_replay_entry, o_replay_id);
    i_replay_ready = 1'b1;
    @(negedge clock);
    i_replay_ready = 1'b0;
    #1;
    checks++;
    if (o_replay_valid !== 1'b0 || o_fin_valid !== 1'b1 || o_fin_source !== 2'(src)) begin
      errors++;
      $display("FAIL run_fin: got replay_v=%0b fin_v=%0b src=%0d, expected 0 1 %0d",
               o_replay_valid, o_fin_valid, o_fin_source, src);
    end
    $display("fin   src=%0d", o_fin_source);
    i_fin_ready = 1'b1;
    @(negedge clock);
    i_fin_ready = 1'b0;
    #1;
    checks++;
    if (o_fin_valid !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL run_idle: got fin_v=%0b idle=%0b, expected 0 1", o_fin_valid, o_idle);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_idle: got ready=%0b idle=%0b, expected 1 1", o_req_ready, o_idle);
    end
    checks++;
    if ({o_acq_valid, o_replay_valid, o_fin_valid, o_gnt_err, o_req_sec} !== 5'b0 ||
        o_acq_addr !== 32'h0 || o_replay_id !== 6'h0) begin
      errors++;
      $display("FAIL reset_outputs: got acq=%0b rep=%0b fin=%0b err=%0b sec=%0b addr=%h id=%0d, expected all 0",
               o_acq_valid, o_replay_valid, o_fin_valid, o_gnt_err, o_req_sec, o_acq_addr, o_replay_id);
    end
    $display("reset done idle=%0b ready=%0b", o_idle, o_req_ready);
    reset = 1'b0;
  endtask

  task automatic test_single_miss();
    @(negedge clock);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h1040;
    i_req_id    = 6'd5;
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_req_sec !== 1'b0) begin
      errors++;
      $display("FAIL single_req: got ready=%0b sec=%0b, expected 1 0", o_req_ready, o_req_sec);
    end
    $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    @(negedge clock);
    i_req_valid = 1'b0;
    run_entry(0, 32'h1040, 6'd5);
  endtask

  task automatic test_merge();
    @(negedge clock);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h2000;
    i_req_id    = 6'd1;
    #1;
    $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    @(negedge clock);
    i_req_valid = 1'b0;
    i_acq_ready = 1'b1;
    #1;
    checks++;
    if (o_acq_valid !== 1'b1 || o_acq_addr !== 32'h2000) begin
      errors++;
      $display("FAIL merge_acq: got v=%0b addr=%h, expected 1 00002000", o_acq_valid, o_acq_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      i_req_valid = 1'b1;
      i_req_addr  = (k == 0) ? 32'h2008 : 32'h2010;
      i_req_id    = 6'(k + 2);
      #1;
      checks++;
      if (o_req_ready !== 1'b1 || o_req_sec !== 1'b1 || o_acq_valid !== 1'b0) begin
        errors++;
        $display("FAIL merge_sec: id=%0d got ready=%0b sec=%0b acq_v=%0b, expected 1 1 0",
                 i_req_id, o_req_ready, o_req_sec, o_acq_valid);
      end
      $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    end
    @(negedge clock);
    i_req_valid = 1'b0;
    i_acq_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_gnt_valid  = 1'b1;
      i_gnt_source = 2'd0;
      @(negedge clock);
    end
    i_gnt_valid    = 1'b0;
    i_replay_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_replay_valid !== 1'b1 || o_replay_id !== 6'(k + 1)) begin
        errors++;
        $display("FAIL merge_replay: got v=%0b id=%0d, expected v=1 id=%0d", o_replay_valid, o_replay_id, k + 1);
      end
      $display("replay entry=%0d id=%0d", o_replay_entry, o_replay_id);
      @(negedge clock);
    end
    i_replay_ready = 1'b0;
    #1;
    checks++;
    if (o_fin_valid !== 1'b1 || o_fin_source !== 2'd0 || o_replay_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_fin: got fin_v=%0b src=%0d rep_v=%0b, expected 1 0 0", o_fin_valid, o_fin_source, o_replay_valid);
    end
    i_fin_ready = 1'b1;
    @(negedge clock);
    i_fin_ready = 1'b0;
    #1;
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL merge_idle: got idle=%0b, expected 1", o_idle);
    end
    $display("fin   src=0 idle=%0b", o_idle);
  endtask

  task automatic test_rpq_full();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      i_req_valid = 1'b1;
      i_req_addr  = 32'h3000 + 32'(8 * k);
      i_req_id    = 6'(10 + k);
      #1;
      checks++;
      if (o_req_ready !== 1'b1 || o_req_sec !== (k != 0)) begin
        errors++;
        $display("FAIL full_fill: k=%0d got ready=%0b sec=%0b, expected 1 %0b", k, o_req_ready, o_req_sec, k != 0);
      end
      $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    end
    @(negedge clock);
    i_req_addr = 32'h3004;
    i_req_id   = 6'd18;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: got ready=%0b, expected 0", o_req_ready);
    end
    $display("req   addr=%h id=%0d ready=%0b (queue full)", i_req_addr, i_req_id, o_req_ready);
    i_acq_ready = 1'b1;
    @(negedge clock);
    i_acq_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_gnt_valid  = 1'b1;
      i_gnt_source = 2'd0;
      @(negedge clock);
    end
    i_gnt_valid    = 1'b0;
    i_replay_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (o_replay_valid !== 1'b1 || o_replay_id !== 6'(10 + k) || o_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_drain: got v=%0b id=%0d ready=%0b, expected 1 %0d 0",
                 o_replay_valid, o_replay_id, o_req_ready, 10 + k);
      end
      $display("replay entry=%0d id=%0d", o_replay_entry, o_replay_id);
      @(negedge clock);
    end
    i_replay_ready = 1'b0;
    i_fin_ready    = 1'b1;
    #1;
    checks++;
    if (o_fin_valid !== 1'b1 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_finish: got fin_v=%0b ready=%0b, expected 1 0", o_fin_valid, o_req_ready);
    end
    @(negedge clock);
    i_fin_ready = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_req_sec !== 1'b0) begin
      errors++;
      $display("FAIL full_realloc: got ready=%0b sec=%0b, expected 1 0", o_req_ready, o_req_sec);
    end
    $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    @(negedge clock);
    i_req_valid = 1'b0;
    run_entry(0, 32'h3000, 6'd18);
  endtask

  task automatic test_all_busy();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      i_req_valid = 1'b1;
      i_req_addr  = 32'h4000 + 32'(k * 32'h1000);
      i_req_id    = 6'(20 + k);
      #1;
      checks++;
      if (o_req_ready !== 1'b1 || o_req_sec !== 1'b0) begin
        errors++;
        $display("FAIL busy_alloc: k=%0d got ready=%0b sec=%0b, expected 1 0", k, o_req_ready, o_req_sec);
      end
      $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    end
    @(negedge clock);
    i_req_addr = 32'h8000;
    i_req_id   = 6'd24;
    #1;
    checks++;
    if (o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_stall: got ready=%0b, expected 0", o_req_ready);
    end
    i_acq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (o_acq_valid !== 1'b1 || o_acq_source !== 2'(k) || o_acq_addr !== 32'h4000 + 32'(k * 32'h1000)) begin
        errors++;
        $display("FAIL busy_acq_order: got v=%0b src=%0d addr=%h, expected src=%0d", o_acq_valid, o_acq_source, o_acq_addr, k);
      end
      $display("acq   src=%0d addr=%h", o_acq_source, o_acq_addr);
      @(negedge clock);
    end
    i_acq_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_gnt_valid  = 1'b1;
      i_gnt_source = 2'd2;
      @(negedge clock);
    end
    i_gnt_valid = 1'b0;
    #1;
    checks++;
    if (o_replay_valid !== 1'b1 || o_replay_entry !== 2'd2 || o_replay_id !== 6'd22 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_replay2: got v=%0b entry=%0d id=%0d ready=%0b, expected 1 2 22 0",
               o_replay_valid, o_replay_entry, o_replay_id, o_req_ready);
    end
    i_replay_ready = 1'b1;
    @(negedge clock);
    i_replay_ready = 1'b0;
    i_fin_ready    = 1'b1;
    #1;
    checks++;
    if (o_fin_valid !== 1'b1 || o_fin_source !== 2'd2 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_fin_same_cycle: got fin_v=%0b src=%0d ready=%0b, expected 1 2 0",
               o_fin_valid, o_fin_source, o_req_ready);
    end
    $display("fin   src=%0d", o_fin_source);
    @(negedge clock);
    i_fin_ready = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_req_sec !== 1'b0) begin
      errors++;
      $display("FAIL busy_reuse: got ready=%0b sec=%0b, expected 1 0", o_req_ready, o_req_sec);
    end
    $display("req   addr=%h id=%0d ready=%0b sec=%0b", i_req_addr, i_req_id, o_req_ready, o_req_sec);
    @(negedge clock);
    i_req_valid = 1'b0;
    #1;
    checks++;
    if (o_acq_valid !== 1'b1 || o_acq_source !== 2'd2 || o_acq_addr !== 32'h8000) begin
      errors++;
      $display("FAIL busy_new_acq: got v=%0b src=%0d addr=%h, expected 1 2 00008000", o_acq_valid, o_acq_source, o_acq_addr);
    end
    i_acq_ready = 1'b1;
    @(negedge clock);
    i_acq_ready = 1'b0;
    for (int e = 0; e < 4; e++) begin
      for (int b = 0; b < 4; b++) begin
        i_gnt_valid  = 1'b1;
        i_gnt_source = 2'(e);
        @(negedge clock);
      end
    end
    i_gnt_valid    = 1'b0;
    i_replay_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (o_replay_valid !== 1'b1 || o_replay_entry !== 2'(k) || o_replay_id !== ((k == 2) ? 6'd24 : 6'(20 + k))) begin
        errors++;
        $display("FAIL busy_replay_order: got v=%0b entry=%0d id=%0d, expected entry=%0d", o_replay_valid, o_replay_entry, o_replay_id, k);
      end
      $display("replay entry=%0d id=%0d", o_replay_entry, o_replay_id);
      @(negedge clock);
    end
    i_replay_ready = 1'b0;
    i_fin_ready    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (o_fin_valid !== 1'b1 || o_fin_source !== 2'(k)) begin
        errors++;
        $display("FAIL busy_fin_order: got v=%0b src=%0d, expected 1 %0d", o_fin_valid, o_fin_source, k);
      end
      $display("fin   src=%0d", o_fin_source);
      @(negedge clock);
    end
    i_fin_ready = 1'b0;
    #1;
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL busy_idle: got idle=%0b, expected 1", o_idle);
    end
  endtask

  task automatic test_gnt_err();
    @(negedge clock);
    i_gnt_valid  = 1'b1;
    i_gnt_source = 2'd3;
    #1;
    checks++;
    if (o_gnt_err !== 1'b0) begin
      errors++;
      $display("FAIL gnt_err_early: got %0b, expected 0", o_gnt_err);
    end
    @(negedge clock);
    i_gnt_valid = 1'b0;
    #1;
    checks++;
    if (o_gnt_err !== 1'b1 || o_idle !== 1'b1 || o_req_ready !== 1'b1 || o_acq_valid !== 1'b0) begin
      errors++;
      $display("FAIL gnt_err_pulse: got err=%0b idle=%0b ready=%0b acq_v=%0b, expected 1 1 1 0",
               o_gnt_err, o_idle, o_req_ready, o_acq_valid);
    end
    $display("grant src=3 (invalid) err=%0b", o_gnt_err);
    @(negedge clock);
    #1;
    checks++;
    if (o_gnt_err !== 1'b0) begin
      errors++;
      $display("FAIL gnt_err_clear: got %0b, expected 0", o_gnt_err);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h9040;
    i_req_id    = 6'd30;
    @(negedge clock);
    i_req_valid = 1'b0;
    i_acq_ready = 1'b1;
    @(negedge clock);
    i_acq_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_gnt_valid  = 1'b1;
      i_gnt_source = 2'd0;
      @(negedge clock);
    end
    i_gnt_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (o_idle !== 1'b1 || o_req_ready !== 1'b1 ||
        {o_acq_valid, o_replay_valid, o_fin_valid, o_gnt_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid: got idle=%0b ready=%0b acq=%0b rep=%0b fin=%0b err=%0b, expected 1 1 0 0 0 0",
               o_idle, o_req_ready, o_acq_valid, o_replay_valid, o_fin_valid, o_gnt_err);
    end
    $display("reset mid-operation idle=%0b", o_idle);
    @(negedge clock);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h9080;
    i_req_id    = 6'd31;
    #1;
    checks++;
    if (o_req_ready !== 1'b1 || o_req_sec !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_realloc: got ready=%0b sec=%0b, expected 1 0", o_req_ready, o_req_sec);
    end
    @(negedge clock);
    i_req_valid = 1'b0;
    run_entry(0, 32'h9080, 6'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    i_req_valid    = 1'b0;
    i_req_addr     = '0;
    i_req_id       = '0;
    i_acq_ready    = 1'b0;
    i_gnt_valid    = 1'b0;
    i_gnt_source   = '0;
    i_replay_ready = 1'b0;
    i_fin_ready    = 1'b0;
    test_reset();
    test_single_miss();
    test_merge();
    test_rpq_full();
    test_all_busy();
    test_gnt_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
